// File: rtl/data_sync_pulse.sv
// Destination-side CDC synchronizer: a level enable crosses a NUM_STAGES flop chain and its
// rising edge captures the (source-held) data bus, emits a one-cycle strobe and bumps a saturating count.
module data_sync_pulse #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 enable_pulse,
    output logic [CNT_WIDTH-1:0] capture_cnt,
    output logic                 busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [NUM_STAGES-1:0] stage_q;
    logic [NUM_STAGES-1:0] stage_d;
    logic                  prev_q;
    logic                  prev_d;
    logic [BUS_WIDTH-1:0]  sync_bus_q;
    logic [BUS_WIDTH-1:0]  sync_bus_d;
    logic                  enable_pulse_q;
    logic                  enable_pulse_d;
    logic [CNT_WIDTH-1:0]  capture_cnt_q;
    logic [CNT_WIDTH-1:0]  capture_cnt_d;
    logic                  sync_en_s;
    logic                  pulse_comb_s;

    assign sync_en_s    = stage_q[NUM_STAGES-1];
    assign pulse_comb_s = sync_en_s & ~prev_q;

    // Next-state: shift the enable through the chain, capture the bus on the synchronized rising edge.
    always_comb begin
        stage_d        = {stage_q[NUM_STAGES-2:0], bus_enable};
        prev_d         = sync_en_s;
        sync_bus_d     = sync_bus_q;
        enable_pulse_d = 1'b0;
        capture_cnt_d  = capture_cnt_q;
        if (pulse_comb_s) begin
            sync_bus_d     = unsync_bus;
            enable_pulse_d = 1'b1;
            if (&capture_cnt_q) begin
                capture_cnt_d = capture_cnt_q;
            end else begin
                capture_cnt_d = capture_cnt_q + CNT_ONE;
            end
        end else begin
            sync_bus_d     = sync_bus_q;
            enable_pulse_d = 1'b0;
            capture_cnt_d  = capture_cnt_q;
        end
    end

    // State registers; reset dominates any capture in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stage_q        <= '0;
            prev_q         <= 1'b0;
            sync_bus_q     <= '0;
            enable_pulse_q <= 1'b0;
            capture_cnt_q  <= '0;
        end else begin
            stage_q        <= stage_d;
            prev_q         <= prev_d;
            sync_bus_q     <= sync_bus_d;
            enable_pulse_q <= enable_pulse_d;
            capture_cnt_q  <= capture_cnt_d;
        end
    end

    // busy is the chain output flop itself, so it is already registered.
    assign sync_bus     = sync_bus_q;
    assign enable_pulse = enable_pulse_q;
    assign capture_cnt  = capture_cnt_q;
    assign busy         = sync_en_s;

endmodule

// File: tb/tb_data_sync_pulse.sv
// Directed bench for data_sync_pulse: default build plus a NUM_STAGES=3 / 16-bit build.
module tb_data_sync_pulse;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  unsync_bus;
    logic        bus_enable;
    logic [7:0]  sync_bus;
    logic        enable_pulse;
    logic [7:0]  capture_cnt;
    logic        busy;

    logic [15:0] unsync_bus2;
    logic        bus_enable2;
    logic [15:0] sync_bus2;
    logic        enable_pulse2;
    logic [7:0]  capture_cnt2;
    logic        busy2;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    int dbl = 0;
    logic last_pulse = 1'b0;

    always #5 CLK = ~CLK;

    data_sync_pulse dut (
        .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
        .sync_bus(sync_bus), .enable_pulse(enable_pulse), .capture_cnt(capture_cnt), .busy(busy)
    );

    data_sync_pulse #(.NUM_STAGES(3), .BUS_WIDTH(16), .CNT_WIDTH(8)) dut2 (
        .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus2), .bus_enable(bus_enable2),
        .sync_bus(sync_bus2), .enable_pulse(enable_pulse2), .capture_cnt(capture_cnt2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle 1ns and record pulse activity.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (enable_pulse === 1'b1) pulses++;
        if (enable_pulse === 1'b1 && last_pulse === 1'b1) dbl++;
        last_pulse = enable_pulse;
    endtask

    task automatic hold(input logic en, input int n);
        bus_enable = en;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        bus_enable = 1'b0;
        bus_enable2 = 1'b0;
    endtask

    initial begin
        RST = 1'b1; unsync_bus = 8'hFF; bus_enable = 1'b1;
        unsync_bus2 = 16'hFFFF; bus_enable2 = 1'b0;

        // Reset held for two edges with enable high.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_bus", 32'(sync_bus), 32'h0);
            chk("rst_pulse", 32'(enable_pulse), 32'h0);
            chk("rst_cnt", 32'(capture_cnt), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
        end
        chk("rst_bus2", 32'(sync_bus2), 32'h0);
        RST = 1'b0; bus_enable = 1'b0;
        hold(1'b0, 3);
        chk("idle_cnt", 32'(capture_cnt), 32'h0);

        // Single transfer, enable held 6 sampled cycles.
        unsync_bus = 8'hA5; bus_enable = 1'b1;
        tick();
        chk("s_k0_pulse", 32'(enable_pulse), 32'h0);
        chk("s_k0_busy", 32'(busy), 32'h0);
        tick();
        chk("s_k1_pulse", 32'(enable_pulse), 32'h0);
        chk("s_k1_busy", 32'(busy), 32'h1);
        tick();
        chk("s_k2_pulse", 32'(enable_pulse), 32'h1);
        chk("s_k2_bus", 32'(sync_bus), 32'hA5);
        chk("s_k2_cnt", 32'(capture_cnt), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s_hold_pulse", 32'(enable_pulse), 32'h0);
            chk("s_hold_bus", 32'(sync_bus), 32'hA5);
        end
        bus_enable = 1'b0;
        tick();
        chk("s_fall1_busy", 32'(busy), 32'h1);
        tick();
        chk("s_fall2_busy", 32'(busy), 32'h0);
        chk("s_end_cnt", 32'(capture_cnt), 32'h1);

        // Two transfers separated by three low cycles.
        do_reset();
        pulses = 0;
        unsync_bus = 8'h3C; hold(1'b1, 4); hold(1'b0, 3);
        unsync_bus = 8'hC3; hold(1'b1, 4); hold(1'b0, 3);
        chk("two_pulses", 32'(pulses), 32'd2);
        chk("two_bus", 32'(sync_bus), 32'hC3);
        chk("two_cnt", 32'(capture_cnt), 32'h2);

        // Back-to-back: exactly one low sampled cycle re-arms.
        pulses = 0;
        unsync_bus = 8'h11; hold(1'b1, 3); hold(1'b0, 1);
        unsync_bus = 8'h22; hold(1'b1, 3); hold(1'b0, 4);
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_bus", 32'(sync_bus), 32'h22);
        chk("b2b_cnt", 32'(capture_cnt), 32'h4);

        // Reset while stage[0] holds the sampled enable.
        do_reset();
        hold(1'b0, 2);
        unsync_bus = 8'h5A; bus_enable = 1'b1;
        tick();
        RST = 1'b1;
        tick();
        chk("rm_rst_pulse", 32'(enable_pulse), 32'h0);
        chk("rm_rst_busy", 32'(busy), 32'h0);
        chk("rm_rst_cnt", 32'(capture_cnt), 32'h0);
        RST = 1'b0;
        tick();
        chk("rm_k0_pulse", 32'(enable_pulse), 32'h0);
        tick();
        chk("rm_k1_pulse", 32'(enable_pulse), 32'h0);
        chk("rm_k1_busy", 32'(busy), 32'h1);
        tick();
        chk("rm_k2_pulse", 32'(enable_pulse), 32'h1);
        chk("rm_k2_bus", 32'(sync_bus), 32'h5A);
        chk("rm_k2_cnt", 32'(capture_cnt), 32'h1);
        tick();
        chk("rm_k3_pulse", 32'(enable_pulse), 32'h0);
        hold(1'b0, 3);

        // Saturation: 260 transfers of incrementing data.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 260; i++) begin
            unsync_bus = 8'(i);
            hold(1'b1, 3);
            hold(1'b0, 2);
            if (i == 253) chk("sat_cnt_254", 32'(capture_cnt), 32'hFE);
            if (i == 254) chk("sat_cnt_255", 32'(capture_cnt), 32'hFF);
        end
        chk("sat_pulses", 32'(pulses), 32'd260);
        chk("sat_cnt", 32'(capture_cnt), 32'hFF);
        chk("sat_bus", 32'(sync_bus), 32'h03);

        // Deep chain, wide bus.
        do_reset();
        hold(1'b0, 2);
        unsync_bus2 = 16'hBEEF; bus_enable2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("p3_early_pulse", 32'(enable_pulse2), 32'h0);
        end
        chk("p3_busy", 32'(busy2), 32'h1);
        tick();
        chk("p3_pulse", 32'(enable_pulse2), 32'h1);
        chk("p3_bus", 32'(sync_bus2), 32'hBEEF);
        chk("p3_cnt", 32'(capture_cnt2), 32'h1);
        tick();
        chk("p3_after_pulse", 32'(enable_pulse2), 32'h0);

        chk("pulse_width", 32'(dbl), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
